// File: rtl/wildcard_sel_decoder.sv
// wildcard_sel_decoder
// -----------------------------------------------------------------------------
// Buffered wildcard decoder. An index plus a care-mask is decoded into the
// select vector of every position whose index matches on the cared bits
// (cleared care bits behave like '?' in a casez item). Decoded vectors are
// queued in a 2-entry valid/ready FIFO before reaching the consumer.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      block can accept a request (registered)
//   in_idx     in   IDX_W  target index
//   in_care    in   IDX_W  care-mask, 1 = compare bit, 0 = don't-care
//   out_valid  out  1      head entry valid
//   out_ready  in   1      consumer takes the head
//   out_sel    out  OUT_W  decoded select vector, 0 when empty
//   txn_cnt    out  CNT_W  completed output transfers, wraps
// -----------------------------------------------------------------------------
module wildcard_sel_decoder #(
   parameter  int IDX_W = 2,
   parameter  int CNT_W = 8,
   localparam int OUT_W = 2**IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [IDX_W-1:0] in_care,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_sel,
   output logic [CNT_W-1:0] txn_cnt
);

   logic [OUT_W-1:0] dec_sel;
   logic [OUT_W-1:0] mem_q [2];
   logic [OUT_W-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
   logic             push;
   logic             pop;

   // A position is selected when it differs from the index only in
   // don't-care bits, so a cleared mask selects everything.
   always_comb begin
      dec_sel = '0;
      for (int i = 0; i < OUT_W; i++) begin
         dec_sel[i] = (((IDX_W)'(i) ^ in_idx) & in_care) == '0;
      end
   end

   assign push = in_valid && in_ready_q;
   assign pop  = out_valid && out_ready;

   // Next-state for storage, pointers, occupancy and the transfer counter.
   // in_ready is registered from the next occupancy, so a full FIFO never
   // sees a push and push+pop at count 2 cannot happen.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q ^ push;
      rd_ptr_d  = rd_ptr_q ^ pop;
      count_d   = count_q;
      txn_cnt_d = txn_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = dec_sel;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (pop) begin
         txn_cnt_d = txn_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b0;
         txn_cnt_q  <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         txn_cnt_q  <= txn_cnt_d;
      end
   end

   // Outputs derive directly from flops, so reset clears them at once.
   assign out_valid = (count_q != 2'd0);
   assign out_sel   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign in_ready  = in_ready_q;
   assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_wildcard_sel_decoder.sv
// tb_wildcard_sel_decoder
// -----------------------------------------------------------------------------
// Self-checking bench for wildcard_sel_decoder. Accepted requests push their
// expected select vector into a scoreboard queue; a negedge monitor compares
// the head against out_sel and tracks the expected transfer count. A second
// instance with a 4-bit counter exercises counter wrap on the same traffic.
// -----------------------------------------------------------------------------
module tb_wildcard_sel_decoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] in_idx;
   logic [1:0] in_care;
   logic       out_ready;
   logic       in_ready, out_valid;
   logic [3:0] out_sel;
   logic [7:0] txn_cnt;
   logic       in_ready4, out_valid4;
   logic [3:0] out_sel4;
   logic [3:0] txn_cnt4;

   int         num_checks;
   int         num_errors;
   int         exp_txn;
   int         stall_cycles;
   bit         mon_en;
   logic [3:0] sb_q[$];

   wildcard_sel_decoder #(.IDX_W(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_idx(in_idx), .in_care(in_care),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel), .txn_cnt(txn_cnt)
   );

   wildcard_sel_decoder #(.IDX_W(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_idx(in_idx), .in_care(in_care),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_sel(out_sel4), .txn_cnt(txn_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode: position i matches when it agrees with idx on cared bits.
   function automatic logic [3:0] modelSel(input logic [1:0] idx, input logic [1:0] care);
      logic [3:0] s;
      s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] pos;
         pos = i[1:0];
         if (((pos ^ idx) & care) == 2'b00) s[i] = 1'b1;
      end
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      num_checks++;
      if (got !== want) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Drive one request and hold it until accepted; returns one step after the
   // accepting edge. Cycles spent waiting on in_ready are counted as stalls.
   task automatic applyStimulus(input logic [1:0] idx, input logic [1:0] care);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_idx   = idx;
      in_care  = care;
      for (int n = 0; n < 50 && !accepted; n++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         else stall_cycles++;
         @(posedge clk);
         #1;
      end
      if (!accepted) checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) checkOutput("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Asserts reset, checks that outputs clear immediately, then releases it
   // away from the edge and checks in_ready rises on the following edge.
   task automatic resetDut();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_sel", out_sel, 0);
      checkOutput("rst_txn_cnt", txn_cnt, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("rel_in_ready_high", in_ready, 1);
   endtask

   always @(negedge rst_n) begin
      sb_q.delete();
      exp_txn = 0;
   end

   // Scoreboard monitor: compare before applying the handshakes that will
   // complete on the coming rising edge.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         logic [7:0] exp8;
         exp8 = exp_txn[7:0];
         checkOutput("out_valid", out_valid, (sb_q.size() != 0) ? 1 : 0);
         if (sb_q.size() != 0) checkOutput("out_sel", out_sel, sb_q[0]);
         else checkOutput("out_sel_idle", out_sel, 0);
         checkOutput("txn_cnt", txn_cnt, exp8);
         if (sb_q.size() != 0 && out_ready) begin
            void'(sb_q.pop_front());
            exp_txn++;
         end
         if (in_valid && in_ready) sb_q.push_back(modelSel(in_idx, in_care));
      end
   end

   initial begin
      logic [3:0] wild_exp [3];
      logic [1:0] wild_idx [3];
      logic [1:0] wild_care[3];
      num_checks   = 0;
      num_errors   = 0;
      exp_txn      = 0;
      stall_cycles = 0;
      mon_en       = 1'b0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_idx       = 2'b00;
      in_care      = 2'b00;
      out_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      resetDut();

      // One-hot decode after reset
      out_ready = 1'b1;
      applyStimulus(2'd2, 2'b11);
      @(negedge clk);
      checkOutput("onehot_sel", out_sel, 4'b0100);
      @(posedge clk);
      #1;
      checkOutput("onehot_txn", txn_cnt, 1);

      // Wildcard patterns
      wild_idx[0] = 2'd3; wild_care[0] = 2'b10; wild_exp[0] = 4'b1100;
      wild_idx[1] = 2'd0; wild_care[1] = 2'b01; wild_exp[1] = 4'b0101;
      wild_idx[2] = 2'd1; wild_care[2] = 2'b00; wild_exp[2] = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(wild_idx[k], wild_care[k]);
         @(negedge clk);
         checkOutput("wild_sel", out_sel, {28'd0, wild_exp[k]});
         @(posedge clk);
         #1;
      end
      checkOutput("wild_txn", txn_cnt, 4);

      // Backpressure: only two requests fit, head holds steady
      out_ready = 1'b0;
      applyStimulus(2'd0, 2'b11);
      applyStimulus(2'd1, 2'b11);
      in_valid = 1'b1;
      in_idx   = 2'd2;
      in_care  = 2'b11;
      repeat (3) begin
         @(negedge clk);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_hold_sel", out_sel, 4'b0001);
         checkOutput("bp_hold_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(2'd2, 2'b11);
      waitDrain();
      checkOutput("bp_txn", txn_cnt, 7);

      // Streaming: 20 back-to-back random requests with no stalls
      resetDut();
      out_ready    = 1'b1;
      stall_cycles = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      checkOutput("stream_stalls", stall_cycles, 0);
      waitDrain();
      checkOutput("stream_txn", txn_cnt, 20);
      checkOutput("stream_txn4", txn_cnt4, 4);

      // Counter wrap on the 4-bit instance
      resetDut();
      for (int k = 0; k < 17; k++) begin
         applyStimulus(2'(k % 4), 2'b11);
      end
      waitDrain();
      checkOutput("wrap_txn4", txn_cnt4, 1);
      checkOutput("wrap_txn8", txn_cnt, 17);

      // Reset with two entries buffered
      out_ready = 1'b0;
      applyStimulus(2'd1, 2'b11);
      applyStimulus(2'd3, 2'b01);
      @(negedge clk);
      checkOutput("mid_in_ready_full", in_ready, 0);
      @(posedge clk);
      #3;
      resetDut();
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("mid_no_stale", out_valid, 0);
      end
      @(posedge clk);
      #1;

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
